// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: single source of stall control for a five-stage pipeline.
// It arbitrates stall requests from IF, ID and MEM. It also sequences
// multi-cycle EX operations (mul/div) by holding the front of the pipeline
// until the final EX cycle of the operation.
//
// Stall vector bits: 0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB.
// If bit k=1 and bit k+1=0, a bubble is injected into stage k+1.
// If bit k=1 and bit k+1=1, stage k+1 is held.
//
// Optional build macro STALL_PERF_CNT_EN adds a saturating 32-bit
// "stall_cycles" counter. It counts clock edges on which the PC is stalled.
module pipe_stall_ctrl #(
  parameter int STALL_W  = 6,
  parameter int MC_CNT_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_stallreq,
  input  logic                id_stallreq,
  input  logic                mem_stallreq,
  input  logic                ex_mc_start,
  input  logic [MC_CNT_W-1:0] ex_mc_cycles,
  input  logic                ctrl_flush,
`ifdef STALL_PERF_CNT_EN
  output logic [31:0]         stall_cycles,
`endif
  output logic [STALL_W-1:0]  ctrl_stall,
  output logic                ex_mc_busy,
  output logic                ex_mc_done
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Returns a vector with bits [k-1:0] set. A requester at stage k holds
  // every register upstream of itself, and the register just after it
  // receives a bubble.
  function automatic logic [STALL_W-1:0] hold_upto(input int k);
    logic [STALL_W-1:0] m;
    m = '0;
    for (int i = 0; i < STALL_W; i++) begin
      if (i < k) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [STALL_W-1:0] STALL_MEM  = hold_upto(5);
  localparam logic [STALL_W-1:0] STALL_EX   = hold_upto(4);
  localparam logic [STALL_W-1:0] STALL_ID   = hold_upto(3);
  localparam logic [STALL_W-1:0] STALL_IF   = hold_upto(2);
  localparam logic [STALL_W-1:0] STALL_NONE = '0;

  localparam logic [MC_CNT_W-1:0] CNT_ONE = MC_CNT_W'(1);
  localparam logic [MC_CNT_W-1:0] CNT_TWO = MC_CNT_W'(2);

  state_t              state_q, state_d;
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;
  logic                ex_req;
  logic                done_raw;

  // Sequencer state and down-counter. An asynchronous reset aborts any
  // operation that is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and EX stall request. While a MEM wait is active in
  // BUSY, the counter and state freeze and the EX request stays asserted,
  // so the done pulse slips until memory releases.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ex_req   = 1'b0;
    done_raw = 1'b0;
    if (ctrl_flush) begin
      // A flush kills any op in flight and refuses a simultaneous launch.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ex_mc_start) begin
            if (ex_mc_cycles >= CNT_TWO) begin
              ex_req  = 1'b1;
              state_d = BUSY;
              cnt_d   = ex_mc_cycles - CNT_ONE;
            end else begin
              // N of 0 or 1 behaves as an ordinary single-cycle op.
              done_raw = 1'b1;
            end
          end
        end
        BUSY: begin
          if (mem_stallreq) begin
            ex_req = 1'b1;
          end else if (cnt_q > CNT_ONE) begin
            ex_req = 1'b1;
            cnt_d  = cnt_q - CNT_ONE;
          end else begin
            // Final EX cycle. The counter is never loaded below 1 in BUSY,
            // so it cannot wrap.
            done_raw = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Stall arbitration, highest priority first: flush, mem, ex, id, if.
  // All outputs are forced low while reset is asserted.
  always_comb begin
    ctrl_stall = STALL_NONE;
    if (rst || ctrl_flush) ctrl_stall = STALL_NONE;
    else if (mem_stallreq) ctrl_stall = STALL_MEM;
    else if (ex_req)       ctrl_stall = STALL_EX;
    else if (id_stallreq)  ctrl_stall = STALL_ID;
    else if (if_stallreq)  ctrl_stall = STALL_IF;
  end

  assign ex_mc_busy = (state_q == BUSY) && !rst;
  assign ex_mc_done = done_raw && !rst;

`ifdef STALL_PERF_CNT_EN
  // Saturating increment so the counter sticks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_q;

  // Count edges on which the PC is stalled. A flush does not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (ctrl_stall[0]) begin
      perf_q <= sat_inc(perf_q);
    end
  end

  assign stall_cycles = perf_q;
`endif

endmodule
